// File: rtl/posit_encoder.sv
// posit_encoder
//   Final stage of the posit pipeline. Takes a denormalized posit
//   {sign, scale, fraction, NaR, zero} and packs it into a POSIT_WIDTH-bit
//   posit word. Rounding is round-to-nearest-even with posit saturation, so
//   a nonzero value never becomes zero or NaR.
//
//   Ports
//     clk, rst_n              clock, asynchronous active-low reset
//     rts_i / rtr_o           upstream handshake (rtr_o is registered)
//     sow_i, eow_i            window tags, carried alongside the data
//     fraction_i              fraction below the hidden 1, MSB-aligned
//     scale_i                 signed power-of-two scale
//     sign_i, NaR_i, zero_i   sign and special-value flags
//     rtr_i / rts_o           downstream handshake
//     sow_o, eow_o, posit_o   encoded word and its tags
//
//   Two pipeline stages (regime build, round & pack). A one-entry skid latch
//   absorbs the word that arrives in the cycle a downstream stall begins,
//   since rtr_o only drops one cycle later.
module posit_encoder #(
  parameter int POSIT_WIDTH = 16,
  parameter int POSIT_ES    = 1,
  parameter int FRAC_W      = 26,
  parameter int SCALE_W     = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rts_i,
  output logic                   rtr_o,
  input  logic                   sow_i,
  input  logic                   eow_i,
  input  logic [FRAC_W-1:0]      fraction_i,
  input  logic [SCALE_W-1:0]     scale_i,
  input  logic                   sign_i,
  input  logic                   NaR_i,
  input  logic                   zero_i,
  input  logic                   rtr_i,
  output logic                   rts_o,
  output logic                   sow_o,
  output logic                   eow_o,
  output logic [POSIT_WIDTH-1:0] posit_o
);

  localparam int N       = POSIT_WIDTH;
  localparam int WORK_W  = N - 1 + FRAC_W;
  localparam int WIDE_W  = WORK_W + N;
  localparam int BODY_W  = 1 + POSIT_ES + FRAC_W;
  localparam int SHIFT_W = $clog2(N + 1);
  localparam int SAT_LIM = (N - 2) << POSIT_ES;

  localparam logic [SCALE_W:0]          LEN_ONE  = (SCALE_W + 1)'(1);
  localparam logic [SCALE_W:0]          LEN_MAX  = (SCALE_W + 1)'(N);
  localparam logic signed [SCALE_W-1:0] SAT_HI_S = SCALE_W'(SAT_LIM);
  localparam logic signed [SCALE_W-1:0] SAT_LO_S = SCALE_W'(-SAT_LIM);

  typedef struct packed {
    logic [FRAC_W-1:0]  fraction;
    logic [SCALE_W-1:0] scale;
    logic               sign;
    logic               nar;
    logic               zero;
    logic               sow;
    logic               eow;
  } in_word_t;

  typedef struct packed {
    logic [WORK_W-1:0] work;
    logic              sign;
    logic              nar;
    logic              zero;
    logic              sat_hi;
    logic              sat_lo;
    logic              sow;
    logic              eow;
  } s1_word_t;

  logic           rtr_q, rtr_d;
  logic           skid_valid_q, skid_valid_d;
  in_word_t       skid_q, skid_d;
  logic           s1_valid_q, s1_valid_d;
  s1_word_t       s1_q, s1_d;
  logic           s2_valid_q, s2_valid_d;
  logic [N-1:0]   posit_q, posit_d;
  logic           sow_q, sow_d;
  logic           eow_q, eow_d;

  logic           process_en, receive_en, src_valid;
  in_word_t       live, src;

  logic signed [SCALE_W-1:0] scale_s, k;
  logic                      regime_pos;
  logic [SCALE_W:0]          run_len;
  logic [SHIFT_W-1:0]        shift_amt;
  logic [BODY_W-1:0]         body;
  logic [WIDE_W-1:0]         wide, fill, shifted;
  s1_word_t                  s1_next;

  logic [N-2:0] top, mag;
  logic         guard, sticky, round_up;
  logic [N-1:0] rounded, word, posit_next;

  assign live = {fraction_i, scale_i, sign_i, NaR_i, zero_i, sow_i, eow_i};

  // Handshake and skid latch. The latch fills only when a word is accepted
  // in a cycle where the pipeline cannot advance, and empties as soon as it
  // can; stage 1 always prefers the latch so order is kept.
  always_comb begin
    process_en   = rtr_i | ~s2_valid_q;
    receive_en   = rts_i & rtr_q;
    rtr_d        = process_en;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    if (process_en) begin
      skid_valid_d = 1'b0;
    end else if (receive_en) begin
      skid_valid_d = 1'b1;
      skid_d       = live;
    end
    src       = skid_valid_q ? skid_q : live;
    src_valid = skid_valid_q | receive_en;
  end

  // Stage 1: regime build. {terminator, e, fraction} is shifted right by the
  // run length, filling with the run bit. The field is N bits wider than the
  // registered working field so bits pushed off the end are folded into its
  // LSB as sticky, keeping tie detection exact.
  always_comb begin
    scale_s    = $signed(src.scale);
    k          = scale_s >>> POSIT_ES;
    regime_pos = ~k[SCALE_W-1];
    if (regime_pos) begin
      run_len = {1'b0, k} + LEN_ONE;
    end else begin
      run_len = -{k[SCALE_W-1], k};
    end
    shift_amt = (run_len > LEN_MAX) ? SHIFT_W'(N) : run_len[SHIFT_W-1:0];
    body      = {~regime_pos, src.scale[POSIT_ES-1:0], src.fraction};
    wide      = {body, {(WIDE_W - BODY_W){1'b0}}};
    fill      = regime_pos ? ~({WIDE_W{1'b1}} >> shift_amt) : '0;
    shifted   = (wide >> shift_amt) | fill;

    s1_next.work   = shifted[WIDE_W-1:N] | {{(WORK_W - 1){1'b0}}, |shifted[N-1:0]};
    s1_next.sign   = src.sign;
    s1_next.nar    = src.nar;
    s1_next.zero   = src.zero;
    s1_next.sat_hi = scale_s > SAT_HI_S;
    s1_next.sat_lo = scale_s < SAT_LO_S;
    s1_next.sow    = src.sow;
    s1_next.eow    = src.eow;

    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (process_en) begin
      s1_valid_d = src_valid;
      s1_d       = src_valid ? s1_next : '0;
    end
  end

  // Stage 2: round to nearest even on the top N-1 bits, then saturate,
  // apply sign and finally the special values (NaR beats zero).
  always_comb begin
    top      = s1_q.work[WORK_W-1 -: N-1];
    guard    = s1_q.work[FRAC_W-1];
    sticky   = |s1_q.work[FRAC_W-2:0];
    round_up = guard & (sticky | top[0]);
    rounded  = {1'b0, top} + {{(N - 1){1'b0}}, round_up};

    if (s1_q.sat_hi || rounded[N-1]) begin
      mag = '1;
    end else if (s1_q.sat_lo || (rounded[N-2:0] == '0)) begin
      mag = {{(N - 2){1'b0}}, 1'b1};
    end else begin
      mag = rounded[N-2:0];
    end

    word = {1'b0, mag};
    if (s1_q.sign) begin
      word = -word;
    end

    if (s1_q.nar) begin
      posit_next = {1'b1, {(N - 1){1'b0}}};
    end else if (s1_q.zero) begin
      posit_next = '0;
    end else begin
      posit_next = word;
    end

    s2_valid_d = s2_valid_q;
    posit_d    = posit_q;
    sow_d      = sow_q;
    eow_d      = eow_q;
    if (process_en) begin
      s2_valid_d = s1_valid_q;
      posit_d    = s1_valid_q ? posit_next : '0;
      sow_d      = s1_valid_q & s1_q.sow;
      eow_d      = s1_valid_q & s1_q.eow;
    end
  end

  // All state; reset discards everything in flight immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rtr_q        <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
      s1_valid_q   <= 1'b0;
      s1_q         <= '0;
      s2_valid_q   <= 1'b0;
      posit_q      <= '0;
      sow_q        <= 1'b0;
      eow_q        <= 1'b0;
    end else begin
      rtr_q        <= rtr_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
      s1_valid_q   <= s1_valid_d;
      s1_q         <= s1_d;
      s2_valid_q   <= s2_valid_d;
      posit_q      <= posit_d;
      sow_q        <= sow_d;
      eow_q        <= eow_d;
    end
  end

  assign rtr_o   = rtr_q;
  assign rts_o   = s2_valid_q;
  assign posit_o = posit_q;
  assign sow_o   = sow_q;
  assign eow_o   = eow_q;

endmodule

// File: tb/tb_posit_encoder.sv
// tb_posit_encoder
//   Scoreboard bench for posit_encoder (N=16, ES=1, 26-bit fraction, 7-bit
//   scale). The driver pushes the reference encoding of every accepted word;
//   an independent monitor compares every presented output against the head
//   of that queue and checks hold-stability while stalled.
module tb_posit_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rts_i, rtr_o, sow_i, eow_i;
  logic [25:0] fraction_i;
  logic [6:0]  scale_i;
  logic        sign_i, NaR_i, zero_i;
  logic        rtr_i, rts_o, sow_o, eow_o;
  logic [15:0] posit_o;

  typedef struct {
    logic [15:0] posit;
    logic        sow;
    logic        eow;
    bit          lat_chk;
    int          acc_cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  bit          rand_rtr = 1'b0;
  bit          stalled_prev = 1'b0;
  logic [15:0] held_posit;
  logic [1:0]  held_tags;

  posit_encoder #(
    .POSIT_WIDTH(16),
    .POSIT_ES   (1),
    .FRAC_W     (26),
    .SCALE_W    (7)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rts_i     (rts_i),
    .rtr_o     (rtr_o),
    .sow_i     (sow_i),
    .eow_i     (eow_i),
    .fraction_i(fraction_i),
    .scale_i   (scale_i),
    .sign_i    (sign_i),
    .NaR_i     (NaR_i),
    .zero_i    (zero_i),
    .rtr_i     (rtr_i),
    .rts_o     (rts_o),
    .sow_o     (sow_o),
    .eow_o     (eow_o),
    .posit_o   (posit_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Random downstream back-pressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rtr) rtr_i = 1'($urandom_range(0, 1));
    end
  end

  // Reference: value = (-1)^sign * 2^scale * 1.frac. Write out the posit bit
  // string (regime run, terminator, exponent, fraction) as an integer, keep
  // 15 magnitude bits and round the discarded tail against exactly one half.
  function automatic logic [15:0] refEncode(input logic [25:0] frac,
                                            input logic signed [6:0] scale,
                                            input logic sign, input logic nar,
                                            input logic zero);
    int s, k, e, len;
    longint unsigned v, mag, rem, half;
    logic [15:0] res;
    if (nar) return 16'h8000;
    if (zero) return 16'h0000;
    s = scale;
    if (s > 28) begin
      mag = 64'h7FFF;
    end else if (s < -28) begin
      mag = 64'd1;
    end else begin
      e   = ((s % 2) + 2) % 2;
      k   = (s - e) / 2;
      v   = 64'd0;
      len = 0;
      if (k >= 0) begin
        for (int i = 0; i <= k; i++) begin v = (v << 1) | 64'd1; len++; end
        v = v << 1; len++;
      end else begin
        for (int i = 0; i < -k; i++) begin v = v << 1; len++; end
        v = (v << 1) | 64'd1; len++;
      end
      v    = (v << 1) | 64'(e); len++;
      v    = (v << 26) | 64'(frac); len += 26;
      mag  = v >> (len - 15);
      rem  = v & ((64'd1 << (len - 15)) - 64'd1);
      half = 64'd1 << (len - 16);
      if (rem > half || (rem == half && (mag & 64'd1) == 64'd1)) mag++;
      if (mag > 64'h7FFF) mag = 64'h7FFF;
      if (mag == 64'd0) mag = 64'd1;
    end
    res = 16'(mag);
    if (sign) res = -res;
    return res;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Present one word, hold it until accepted, and record its expectation.
  task automatic applyStimulus(input logic [25:0] frac, input logic [6:0] scale,
                               input logic sign, input logic nar, input logic zero,
                               input logic sow, input logic eow, input bit lat);
    exp_t ex;
    int   waited = 0;
    bit   ok = 1'b0;
    fraction_i = frac; scale_i = scale; sign_i = sign;
    NaR_i = nar; zero_i = zero; sow_i = sow; eow_i = eow;
    rts_i = 1'b1;
    ex.posit   = refEncode(frac, $signed(scale), sign, nar, zero);
    ex.sow     = sow;
    ex.eow     = eow;
    ex.lat_chk = lat;
    while (!ok && waited < 200) begin
      @(negedge clk);
      if (rtr_o) ok = 1'b1;
      else waited++;
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("[TB] FAIL accept_timeout: rtr_o stayed %b, expected 1 within 200 cycles", rtr_o);
    end else begin
      ex.acc_cyc = cyc;
      exp_q.push_back(ex);
    end
    @(posedge clk);
    #1;
    rts_i = 1'b0;
  endtask

  task automatic sendRandom(input logic sow, input logic eow);
    int          s;
    logic [25:0] frac;
    frac = 26'($urandom);
    if ($urandom_range(0, 3) == 0) frac = frac & 26'h3FFC000;
    if ($urandom_range(0, 9) < 7) s = int'($urandom_range(0, 60)) - 30;
    else s = int'($urandom_range(0, 127)) - 64;
    applyStimulus(frac, 7'(s), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0),
                  sow, eow, 1'b0);
  endtask

  task automatic waitDrain();
    int w = 0;
    while (exp_q.size() != 0 && w < 400) begin
      @(posedge clk);
      w++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL drain_timeout: %0d words still pending, expected 0", exp_q.size());
    end
    #1;
  endtask

  // Monitor: compare every presented word, pop on transfer, and insist the
  // output is frozen while stalled.
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled_prev = 1'b0;
    end else begin
      if (stalled_prev) begin
        checkOutput("hold_rts", {31'd0, rts_o}, 32'd1);
        checkOutput("hold_posit", {16'd0, posit_o}, {16'd0, held_posit});
        checkOutput("hold_tags", {30'd0, sow_o, eow_o}, {30'd0, held_tags});
      end
      if (rts_o) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL spurious_output: got posit %h with no word pending", posit_o);
        end else begin
          checkOutput("posit", {16'd0, posit_o}, {16'd0, exp_q[0].posit});
          checkOutput("sow", {31'd0, sow_o}, {31'd0, exp_q[0].sow});
          checkOutput("eow", {31'd0, eow_o}, {31'd0, exp_q[0].eow});
          if (!stalled_prev && exp_q[0].lat_chk)
            checkOutput("latency", 32'(cyc - exp_q[0].acc_cyc), 32'd2);
          if (rtr_i) void'(exp_q.pop_front());
        end
      end
      stalled_prev = rts_o & ~rtr_i;
      held_posit   = posit_o;
      held_tags    = {sow_o, eow_o};
    end
  end

  initial begin
    rst_n = 1'b0; rts_i = 1'b0; rtr_i = 1'b1;
    sow_i = 1'b0; eow_i = 1'b0; fraction_i = '0; scale_i = '0;
    sign_i = 1'b0; NaR_i = 1'b0; zero_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_rts", {31'd0, rts_o}, 32'd0);
    checkOutput("reset_rtr", {31'd0, rtr_o}, 32'd0);
    checkOutput("reset_posit", {16'd0, posit_o}, 32'd0);
    checkOutput("reset_tags", {30'd0, sow_o, eow_o}, 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] basic encodings and latency");
    applyStimulus(26'h0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1); waitDrain();
    applyStimulus(26'h0, 7'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); waitDrain();
    applyStimulus(26'h0, 7'h7F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); waitDrain();
    applyStimulus(26'h0, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); waitDrain();

    $display("[TB] special values, rounding, saturation");
    applyStimulus(26'($urandom), 7'($urandom), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(26'($urandom), 7'($urandom), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(26'h1234567, 7'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(26'h0002000, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(26'h0006000, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(26'h0002001, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(26'h0, 7'd40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(26'h0, 7'h58, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(26'h0, 7'h58, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(26'h3FFFFFF, 7'd28, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(26'h2000000, 7'd27, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(26'h3FFFFFF, 7'h64, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    waitDrain();

    $display("[TB] streaming with random back-pressure");
    rand_rtr = 1'b1;
    for (int i = 0; i < 8; i++) sendRandom(i == 0, i == 7);
    for (int i = 0; i < 200; i++)
      sendRandom(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    rand_rtr = 1'b0;
    @(posedge clk);
    #2 rtr_i = 1'b1;
    waitDrain();

    $display("[TB] reset with words in flight");
    rtr_i = 1'b0;
    applyStimulus(26'h0, 7'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(26'h0, 7'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    checkOutput("pre_reset_rts", {31'd0, rts_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_reset_rts", {31'd0, rts_o}, 32'd0);
    checkOutput("mid_reset_posit", {16'd0, posit_o}, 32'd0);
    exp_q.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    rtr_i = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(26'h0006000, 7'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    waitDrain();

    repeat (5) @(posedge clk);
    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
